// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS linear frequency sweep controller.
package dds_pkg;

    localparam int INC_WIDTH_DEF   = 32;
    localparam int DWELL_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    typedef struct packed {
        logic [INC_WIDTH_DEF-1:0]   start;
        logic [INC_WIDTH_DEF-1:0]   stop;
        logic [INC_WIDTH_DEF-1:0]   step;
        logic [DWELL_WIDTH_DEF-1:0] dwell;
        logic                       continuous;
    } sweep_cfg_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that flags when the current sweep point's dwell has elapsed.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [DWELL_WIDTH-1:0] i_value,
    output logic                   o_expire
);

    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [DWELL_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_controller.sv
// Steps the DDS phase increment from start to stop with a programmable dwell per point.
// Define DDS_SWEEP_BIDIR_EN for triangular (up/down) continuous sweeps instead of sawtooth.
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int INC_WIDTH   = INC_WIDTH_DEF,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INC_WIDTH-1:0]   i_start_inc,
    input  logic [INC_WIDTH-1:0]   i_stop_inc,
    input  logic [INC_WIDTH-1:0]   i_step_inc,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    input  logic                   i_continuous,
    input  logic                   i_go,
    input  logic                   i_abort,
    output logic [INC_WIDTH-1:0]   o_incremento,
    output logic                   o_inc_valid,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_state
);

    sweep_state_t           state_q, state_d;
    sweep_cfg_t             cfg_q, cfg_d;
    logic                   dir_down_q, dir_down_d;
    logic [INC_WIDTH-1:0]   inc_q, inc_d;
    logic                   valid_q, valid_d;
    logic                   timer_load;
    logic [DWELL_WIDTH-1:0] timer_value;
    logic                   timer_expire;
    logic                   at_end;
`ifdef DDS_SWEEP_BIDIR_EN
    logic                   fwd_q, fwd_d;
    logic                   leg_up;
    logic [INC_WIDTH-1:0]   leg_target;
`endif

    // Computed one bit wider so an overshoot past either rail clamps instead of wrapping.
    function automatic logic [INC_WIDTH-1:0] step_toward(
        input logic [INC_WIDTH-1:0] cur,
        input logic [INC_WIDTH-1:0] step,
        input logic [INC_WIDTH-1:0] target,
        input logic                 up
    );
        logic [INC_WIDTH:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, step};
            if (nxt > {1'b0, target}) nxt = {1'b0, target};
        end else begin
            nxt = {1'b0, cur} - {1'b0, step};
            if (nxt[INC_WIDTH] || (nxt < {1'b0, target})) nxt = {1'b0, target};
        end
        return nxt[INC_WIDTH-1:0];
    endfunction

    function automatic logic [DWELL_WIDTH-1:0] dwell_reload(input logic [DWELL_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
    endfunction

    dds_dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .clock   (clock),
        .reset   (reset),
        .i_load  (timer_load),
        .i_value (timer_value),
        .o_expire(timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        dir_down_d  = dir_down_q;
        inc_d       = inc_q;
        valid_d     = 1'b0;
        timer_load  = 1'b0;
        timer_value = dwell_reload(cfg_q.dwell);
`ifdef DDS_SWEEP_BIDIR_EN
        fwd_d       = fwd_q;
        leg_up      = fwd_q ? ~dir_down_q : dir_down_q;
        leg_target  = fwd_q ? cfg_q.stop : cfg_q.start;
        at_end      = (cfg_q.step == '0) || (inc_q == leg_target);
`else
        at_end      = (cfg_q.step == '0) || (inc_q == cfg_q.stop);
`endif

        if (i_abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_go) begin
                        state_d          = RUN;
                        cfg_d.start      = i_start_inc;
                        cfg_d.stop       = i_stop_inc;
                        cfg_d.step       = i_step_inc;
                        cfg_d.dwell      = i_dwell;
                        cfg_d.continuous = i_continuous;
                        dir_down_d       = (i_stop_inc < i_start_inc);
                        inc_d            = i_start_inc;
                        valid_d          = 1'b1;
                        timer_load       = 1'b1;
                        timer_value      = dwell_reload(i_dwell);
`ifdef DDS_SWEEP_BIDIR_EN
                        fwd_d            = 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (timer_expire) begin
                        valid_d    = 1'b1;
                        timer_load = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
                        if (at_end && fwd_q && !cfg_q.continuous) begin
                            state_d    = DONE;
                            valid_d    = 1'b0;
                            timer_load = 1'b0;
                        end else if (at_end && ((cfg_q.step == '0) || (cfg_q.start == cfg_q.stop))) begin
                            inc_d = cfg_q.start;
                        end else if (at_end) begin
                            // Turn around; the endpoint just held is not repeated.
                            fwd_d = ~fwd_q;
                            inc_d = step_toward(inc_q, cfg_q.step,
                                                fwd_q ? cfg_q.start : cfg_q.stop,
                                                fwd_q ? dir_down_q : ~dir_down_q);
                        end else begin
                            inc_d = step_toward(inc_q, cfg_q.step, leg_target, leg_up);
                        end
`else
                        if (at_end && !cfg_q.continuous) begin
                            state_d    = DONE;
                            valid_d    = 1'b0;
                            timer_load = 1'b0;
                        end else if (at_end) begin
                            inc_d = cfg_q.start;
                        end else begin
                            inc_d = step_toward(inc_q, cfg_q.step, cfg_q.stop, ~dir_down_q);
                        end
`endif
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            dir_down_q <= 1'b0;
            inc_q      <= '0;
            valid_q    <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
            fwd_q      <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            dir_down_q <= dir_down_d;
            inc_q      <= inc_d;
            valid_q    <= valid_d;
`ifdef DDS_SWEEP_BIDIR_EN
            fwd_q      <= fwd_d;
`endif
        end
    end

    assign o_incremento = inc_q;
    assign o_inc_valid  = valid_q;
    assign o_busy       = (state_q == RUN);
    assign o_done       = (state_q == DONE);
    assign o_state      = state_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed, table-driven bench for dds_sweep_controller plus hand-written abort/reset sequences.
module tb_dds_sweep_controller;

    logic        clock;
    logic        reset;
    logic [31:0] i_start_inc;
    logic [31:0] i_stop_inc;
    logic [31:0] i_step_inc;
    logic [23:0] i_dwell;
    logic        i_continuous;
    logic        i_go;
    logic        i_abort;
    logic [31:0] o_incremento;
    logic        o_inc_valid;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_state;

    int n_checks = 0;
    int n_fail   = 0;

    dds_sweep_controller dut (
        .clock       (clock),
        .reset       (reset),
        .i_start_inc (i_start_inc),
        .i_stop_inc  (i_stop_inc),
        .i_step_inc  (i_step_inc),
        .i_dwell     (i_dwell),
        .i_continuous(i_continuous),
        .i_go        (i_go),
        .i_abort     (i_abort),
        .o_incremento(o_incremento),
        .o_inc_valid (o_inc_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      start;
        logic [31:0]      stop;
        logic [31:0]      step;
        logic [23:0]      dwell;
        logic             cont;
        bit               mid_go;
        int               n;
        logic [7:0][31:0] seq;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                input logic [23:0] d, input logic c, input bit mg, input int n,
                                input logic [31:0] p0 = 0, input logic [31:0] p1 = 0,
                                input logic [31:0] p2 = 0, input logic [31:0] p3 = 0,
                                input logic [31:0] p4 = 0, input logic [31:0] p5 = 0,
                                input logic [31:0] p6 = 0, input logic [31:0] p7 = 0);
        vec_t v;
        v.start = s; v.stop = e; v.step = st; v.dwell = d; v.cont = c; v.mid_go = mg; v.n = n;
        v.seq[0] = p0; v.seq[1] = p1; v.seq[2] = p2; v.seq[3] = p3;
        v.seq[4] = p4; v.seq[5] = p5; v.seq[6] = p6; v.seq[7] = p7;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int  idx;
        int  hold;
        int  eff;
        bit  finished;
        logic [31:0] last;
        eff      = (v.dwell == 0) ? 1 : int'(v.dwell);
        idx      = 0;
        hold     = 0;
        finished = 0;
        @(negedge clock);
        i_start_inc  = v.start;
        i_stop_inc   = v.stop;
        i_step_inc   = v.step;
        i_dwell      = v.dwell;
        i_continuous = v.cont;
        i_go         = 1'b1;
        @(negedge clock);
        i_go         = 1'b0;
        // Scramble the config inputs: only the values present at go may matter.
        i_start_inc  = 32'h1234_5678;
        i_stop_inc   = 32'h0000_0003;
        i_step_inc   = 32'h0000_0001;
        i_dwell      = 24'd9;
        i_continuous = ~v.cont;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (o_inc_valid) begin
                if (idx > 0) check($sformatf("v%0d_hold%0d", vi, idx - 1), 32'(hold), 32'(eff));
                if (idx < v.n) check($sformatf("v%0d_point%0d", vi, idx), o_incremento, v.seq[idx]);
                else check($sformatf("v%0d_extra_point", vi), 32'(idx), 32'(v.n));
                idx++;
                hold = 1;
                if (v.cont && idx == v.n) finished = 1;
            end else if (o_busy) begin
                hold++;
            end
            if (o_done) begin
                check($sformatf("v%0d_done_in_continuous", vi), {31'b0, v.cont}, 32'd0);
                check($sformatf("v%0d_points_at_done", vi), 32'(idx), 32'(v.n));
                check($sformatf("v%0d_last_hold", vi), 32'(hold), 32'(eff));
                check($sformatf("v%0d_inc_at_done", vi), o_incremento, v.seq[v.n - 1]);
                check($sformatf("v%0d_state_done", vi), {30'b0, o_state}, 32'd2);
                finished = 1;
            end
            if (!finished) begin
                i_go = (v.mid_go && cyc == 2);
                if (v.mid_go && cyc == 2) i_start_inc = 32'd7;
                @(negedge clock);
            end
        end
        i_go = 1'b0;
        check($sformatf("v%0d_finished", vi), {31'b0, finished}, 32'd1);
        last = o_incremento;
        if (v.cont) i_abort = 1'b1;
        @(negedge clock);
        i_abort = 1'b0;
        check($sformatf("v%0d_state_after", vi), {30'b0, o_state}, 32'd0);
        check($sformatf("v%0d_done_after", vi), {31'b0, o_done}, 32'd0);
        check($sformatf("v%0d_inc_after", vi), o_incremento, last);
        $display("vector %0d: start=0x%0h stop=0x%0h step=0x%0h dwell=%0d cont=%0d points=%0d",
                 vi, v.start, v.stop, v.step, v.dwell, v.cont, idx);
    endtask

    initial begin
        bit found;
        vecs[0] = mk(100, 140, 10, 3, 1'b0, 1'b0, 5, 100, 110, 120, 130, 140);
        vecs[1] = mk(100, 125, 10, 1, 1'b0, 1'b0, 4, 100, 110, 120, 125);
        vecs[2] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, 1'b0, 1'b0, 2,
                     32'hFFFF_FFF0, 32'hFFFF_FFFF);
`ifdef DDS_SWEEP_BIDIR_EN
        vecs[3] = mk(50, 20, 10, 0, 1'b1, 1'b0, 8, 50, 40, 30, 20, 30, 40, 50, 40);
`else
        vecs[3] = mk(50, 20, 10, 0, 1'b1, 1'b0, 8, 50, 40, 30, 20, 50, 40, 30, 20);
`endif
        vecs[4] = mk(77, 200, 0, 4, 1'b0, 1'b0, 1, 77);
        vecs[5] = mk(500, 500, 7, 2, 1'b0, 1'b0, 1, 500);
        vecs[6] = mk(1000, 975, 10, 2, 1'b0, 1'b0, 4, 1000, 990, 980, 975);
        vecs[7] = mk(32'h15, 0, 32'h20, 1, 1'b0, 1'b0, 2, 32'h15, 0);
        vecs[8] = mk(100, 130, 10, 2, 1'b0, 1'b1, 4, 100, 110, 120, 130);

        reset = 1'b1; i_go = 1'b0; i_abort = 1'b0; i_continuous = 1'b0;
        i_start_inc = 32'd5; i_stop_inc = 32'd9; i_step_inc = 32'd1; i_dwell = 24'd1;
        repeat (3) @(negedge clock);
        check("reset_state", {30'b0, o_state}, 32'd0);
        check("reset_inc", o_incremento, 32'd0);
        check("reset_flags", {29'b0, o_inc_valid, o_busy, o_done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Abort while the sweep sits on 120.
        @(negedge clock);
        i_start_inc = 100; i_stop_inc = 200; i_step_inc = 10; i_dwell = 2; i_continuous = 1'b0;
        i_go = 1'b1;
        @(negedge clock);
        i_go = 1'b0;
        found = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (o_inc_valid && o_incremento == 32'd120) found = 1;
            else @(negedge clock);
        end
        check("abort_reached_120", {31'b0, found}, 32'd1);
        i_abort = 1'b1;
        @(negedge clock);
        i_abort = 1'b0;
        check("abort_state", {30'b0, o_state}, 32'd0);
        check("abort_busy", {31'b0, o_busy}, 32'd0);
        check("abort_inc_hold", o_incremento, 32'd120);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("abort_quiet%0d", c), {30'b0, o_done, o_inc_valid}, 32'd0);
            @(negedge clock);
        end
        $display("abort sequence: held 0x%0h", o_incremento);

        // Simultaneous go and abort in IDLE.
        i_start_inc = 300; i_stop_inc = 400; i_go = 1'b1; i_abort = 1'b1;
        @(negedge clock);
        i_go = 1'b0; i_abort = 1'b0;
        check("goabort_state", {30'b0, o_state}, 32'd0);
        check("goabort_valid", {31'b0, o_inc_valid}, 32'd0);
        check("goabort_inc", o_incremento, 32'd120);
        $display("go+abort sequence: state=%0d", o_state);

        // Reset in the middle of a sweep.
        i_start_inc = 10; i_stop_inc = 1000; i_step_inc = 1; i_dwell = 1; i_go = 1'b1;
        @(negedge clock);
        i_go = 1'b0;
        repeat (3) @(negedge clock);
        check("midrun_busy", {31'b0, o_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_inc", o_incremento, 32'd0);
        check("midreset_state", {30'b0, o_state}, 32'd0);
        check("midreset_flags", {29'b0, o_inc_valid, o_busy, o_done}, 32'd0);
        $display("mid-sweep reset sequence: inc=0x%0h", o_incremento);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
